nonce_search_ctrl: RTL and testbench

- Parametrised successor to the two-lane miner top: a nonce-search controller that drives NUM_LANES external SHA-256d hash lanes.
- Sweeps a programmable nonce range, compares each lane result against a full 256-bit target and reports the first winning nonce.
- Also reports range exhaustion and supports abort.
- Sits between the block-header source and the hash cores; the hash cores themselves are outside this block.

---
 rtl/nonce_search_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_nonce_search_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_search_ctrl.sv
// ---------------------------------------------------------------------------
// nonce_search_ctrl
//
// Nonce-search controller that feeds NUM_LANES external SHA-256d hash lanes.
// It sweeps an inclusive nonce range, gives each nonce to the lowest idle
// lane, and compares every returned hash against a 256-bit target. It
// reports the first winning nonce, or that the range ran out, and it
// supports abort.
//
// Optional feature macro: NONCE_SEARCH_CTRL_STATS_EN
//   defined   : hash_count counts the lane results consumed in the current
//               search and saturates at all-ones.
//   undefined : no counter register is built and hash_count is tied to 0.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   start        one-cycle pulse; begins a search (accepted in IDLE/DONE)
//   abort        stops an active search (effective in RUN only)
//   nonce_first  first nonce of the range, sampled on accepted start
//   nonce_last   last nonce of the range (inclusive), sampled on start
//   target       unsigned hit threshold, sampled on accepted start
//   lane_go      one-cycle issue pulse per lane
//   lane_nonce   per-lane nonce, byte-reversed (header little-endian order)
//   lane_done    one-cycle result pulse per lane
//   lane_hash    per-lane result, valid with the matching lane_done bit
//   busy         high in RUN and DRAIN
//   found        search ended with a hit
//   exhausted    search ended with no hit after the full range
//   found_nonce  winning nonce in natural order
//   hash_count   lane results consumed in the current search
// ---------------------------------------------------------------------------
module nonce_search_ctrl #(
    parameter int NUM_LANES = 2,
    parameter int NONCE_W   = 32,
    parameter int HASH_W    = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic [NONCE_W-1:0]           nonce_first,
    input  logic [NONCE_W-1:0]           nonce_last,
    input  logic [HASH_W-1:0]            target,
    output logic [NUM_LANES-1:0]         lane_go,
    output logic [NUM_LANES*NONCE_W-1:0] lane_nonce,
    input  logic [NUM_LANES-1:0]         lane_done,
    input  logic [NUM_LANES*HASH_W-1:0]  lane_hash,
    output logic                         busy,
    output logic                         found,
    output logic                         exhausted,
    output logic [NONCE_W-1:0]           found_nonce,
    output logic [31:0]                  hash_count
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [NONCE_W:0]     NEXT_INC = 1;
    localparam logic [NUM_LANES-1:0] LANE_ONE = 1;

    state_t               state;
    logic [NONCE_W-1:0]   last_q;
    logic [HASH_W-1:0]    target_q;
    // One bit wider than a nonce so an all-ones nonce_last cannot wrap.
    logic [NONCE_W:0]     next_q;
    logic [NUM_LANES-1:0] lane_busy;
    logic [NONCE_W-1:0]   lane_val [NUM_LANES];

    logic                 range_empty;
    logic                 accept_start;
    logic                 hit_any;
    logic                 issue_en;
    logic [NUM_LANES-1:0] consumed;
    logic [NUM_LANES-1:0] hit_vec;
    logic [NUM_LANES-1:0] lane_free;
    logic [NUM_LANES-1:0] issue_oh;
    logic [NONCE_W-1:0]   hit_nonce;

    assign range_empty  = next_q > {1'b0, last_q};
    assign accept_start = start && ((state == IDLE) || (state == DONE));
    // Results from lanes we never issued to (or issued before a reset) are dropped.
    assign consumed     = lane_done & lane_busy;
    assign lane_free    = ~lane_busy;
    // Lowest set bit of the free mask. It uses the registered busy flags, so
    // a lane freed this cycle is only reissued on the next cycle.
    assign issue_oh     = lane_free & (~lane_free + LANE_ONE);
    assign busy         = (state == RUN) || (state == DRAIN);

    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            hit_vec[i] = consumed[i] && (lane_hash[i*HASH_W +: HASH_W] <= target_q);
        end
    end

    // Scan from the top down so the lowest-index hitting lane wins.
    always_comb begin
        hit_any   = 1'b0;
        hit_nonce = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit_any   = 1'b1;
                hit_nonce = lane_val[i];
            end
        end
    end

    assign issue_en = (state == RUN) && !range_empty && (|lane_free) && !hit_any && !abort;

    // Lanes expect the nonce in header byte order, so each byte is swapped.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        for (genvar b = 0; b < NONCE_W / 8; b++) begin : g_byte
            assign lane_nonce[i*NONCE_W + b*8 +: 8] = lane_val[i][NONCE_W - 8 - b*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_q      <= '0;
            target_q    <= '0;
            next_q      <= '0;
            lane_busy   <= '0;
            lane_go     <= '0;
            found       <= 1'b0;
            exhausted   <= 1'b0;
            found_nonce <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_val[i] <= '0;
            end
        end else begin
            lane_go   <= '0;
            lane_busy <= lane_busy & ~consumed;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        last_q      <= nonce_last;
                        target_q    <= target;
                        next_q      <= {1'b0, nonce_first};
                        found       <= 1'b0;
                        exhausted   <= 1'b0;
                        found_nonce <= '0;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    // A hit takes priority over a simultaneous abort.
                    if (hit_any) begin
                        found       <= 1'b1;
                        found_nonce <= hit_nonce;
                        state       <= DRAIN;
                    end else if (range_empty && (lane_busy == '0)) begin
                        exhausted <= 1'b1;
                        state     <= DONE;
                    end else if (abort) begin
                        state <= DRAIN;
                    end else if (issue_en) begin
                        lane_go   <= issue_oh;
                        lane_busy <= (lane_busy & ~consumed) | issue_oh;
                        next_q    <= next_q + NEXT_INC;
                    end
                end
                DRAIN: begin
                    if (lane_busy == '0) begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
            for (int i = 0; i < NUM_LANES; i++) begin
                if (issue_en && issue_oh[i]) begin
                    lane_val[i] <= next_q[NONCE_W-1:0];
                end
            end
        end
    end

`ifdef NONCE_SEARCH_CTRL_STATS_EN
    logic [31:0] done_cnt;
    logic [32:0] count_sum;

    // Several lanes can return in the same cycle, so add the whole popcount.
    always_comb begin
        done_cnt = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            done_cnt = done_cnt + 32'(consumed[i]);
        end
        count_sum = {1'b0, hash_count} + {1'b0, done_cnt};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hash_count <= '0;
        end else if (accept_start) begin
            hash_count <= '0;
        end else if (count_sum[32]) begin
            hash_count <= '1;
        end else begin
            hash_count <= count_sum[31:0];
        end
    end
`else
    assign hash_count = '0;
`endif

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nonce_search_ctrl
//
// Drives three controller instances: 1 lane, 2 lanes and 4 lanes. The 1-lane
// and 2-lane instances are served by fixed-latency lane models that recover
// the natural nonce from lane_nonce and return a hash equal to the target
// (a hit) or target+1 (a miss). The 4-lane instance has its results driven
// by hand so that the exact arrival cycle of each result is controlled.
// ---------------------------------------------------------------------------
module tb_nonce_search_ctrl;

    localparam logic [255:0] TGT  = 256'h1000;
    localparam logic [255:0] MISS = 256'h1001;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         abort = 1'b0;
    logic         start1 = 1'b0;
    logic         start2 = 1'b0;
    logic         start4 = 1'b0;
    logic [31:0]  nonce_first = '0;
    logic [31:0]  nonce_last = '0;
    logic [255:0] target = TGT;

    logic [0:0]   go1;
    logic [31:0]  nonce1;
    logic [0:0]   done1;
    logic [255:0] hash1;
    logic         busy1, found1, exh1;
    logic [31:0]  fn1, cnt1;

    logic [1:0]   go2;
    logic [63:0]  nonce2;
    logic [1:0]   done2;
    logic [511:0] hash2;
    logic         busy2, found2, exh2;
    logic [31:0]  fn2, cnt2;
    logic         hit_en2 = 1'b0;
    logic [31:0]  hit_nonce2 = '0;

    logic [3:0]    go4;
    logic [127:0]  nonce4;
    logic [3:0]    done4 = '0;
    logic [1023:0] hash4 = '0;
    logic          busy4, found4, exh4;
    logic [31:0]   fn4, cnt4;

    int n_checks = 0;
    int n_fail = 0;
    int go_cnt1 = 0;
    int go_cnt2 = 0;
    int go_cnt4 = 0;
    logic [31:0] raw5 = '0;

    typedef struct {
        string       name;
        logic [31:0] first;
        logic [31:0] last;
        logic        hit_en;
        logic [31:0] hit_n;
        logic        exp_found;
        logic        exp_exh;
        logic [31:0] exp_fn;
        int          exp_gos;
        int          exp_cnt;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    nonce_search_ctrl #(.NUM_LANES(1), .NONCE_W(32), .HASH_W(256)) u1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort),
        .nonce_first(nonce_first), .nonce_last(nonce_last), .target(target),
        .lane_go(go1), .lane_nonce(nonce1), .lane_done(done1), .lane_hash(hash1),
        .busy(busy1), .found(found1), .exhausted(exh1),
        .found_nonce(fn1), .hash_count(cnt1)
    );

    nonce_search_ctrl #(.NUM_LANES(2), .NONCE_W(32), .HASH_W(256)) u2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort),
        .nonce_first(nonce_first), .nonce_last(nonce_last), .target(target),
        .lane_go(go2), .lane_nonce(nonce2), .lane_done(done2), .lane_hash(hash2),
        .busy(busy2), .found(found2), .exhausted(exh2),
        .found_nonce(fn2), .hash_count(cnt2)
    );

    nonce_search_ctrl #(.NUM_LANES(4), .NONCE_W(32), .HASH_W(256)) u4 (
        .clk(clk), .rst(rst), .start(start4), .abort(abort),
        .nonce_first(nonce_first), .nonce_last(nonce_last), .target(target),
        .lane_go(go4), .lane_nonce(nonce4), .lane_done(done4), .lane_hash(hash4),
        .busy(busy4), .found(found4), .exhausted(exh4),
        .found_nonce(fn4), .hash_count(cnt4)
    );

    function automatic logic [31:0] byteRev(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    function automatic int expCnt(input int n);
`ifdef NONCE_SEARCH_CTRL_STATS_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    // Single-lane model: 4-cycle latency, only nonce 5 hits.
    int          m1_cnt = 0;
    logic [31:0] m1_nn = '0;
    always @(posedge clk) begin
        if (go1[0]) begin
            m1_cnt <= 4;
            m1_nn  <= byteRev(nonce1);
        end else if (m1_cnt != 0) begin
            m1_cnt <= m1_cnt - 1;
        end
    end
    assign done1 = (m1_cnt == 1);
    assign hash1 = (m1_nn == 32'd5) ? TGT : MISS;

    // Two-lane model: 3-cycle latency, the hit nonce is chosen per test.
    // It deliberately ignores rst so that stale results appear after a reset.
    for (genvar i = 0; i < 2; i++) begin : g_m2
        int          cnt = 0;
        logic [31:0] nn = '0;
        always @(posedge clk) begin
            if (go2[i]) begin
                cnt <= 3;
                nn  <= byteRev(nonce2[i*32 +: 32]);
            end else if (cnt != 0) begin
                cnt <= cnt - 1;
            end
        end
        assign done2[i] = (cnt == 1);
        assign hash2[i*256 +: 256] = (hit_en2 && (nn == hit_nonce2)) ? TGT : MISS;
    end

    // Issue-pulse counters, plus the raw lane_nonce of the sixth single-lane issue.
    always @(posedge clk) begin
        go_cnt1 <= go_cnt1 + $countones(go1);
        go_cnt2 <= go_cnt2 + $countones(go2);
        go_cnt4 <= go_cnt4 + $countones(go4);
        if (go1[0] && (go_cnt1 == 5)) begin
            raw5 <= nonce1;
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic busyOf(input int sel);
        case (sel)
            1:       return busy1;
            2:       return busy2;
            default: return busy4;
        endcase
    endfunction

    // Steps until the selected instance drops busy; cyc is the number of steps.
    task automatic waitIdle(input int sel, input string name, output int cyc);
        cyc = 0;
        while (busyOf(sel) && (cyc < 2000)) begin
            stepCycle();
            cyc++;
        end
        checkOutput({name, "_idle_in_budget"}, 64'(busyOf(sel)), 64'd0);
    endtask

    // Runs one search on the two-lane instance. On return the instance is
    // idle; cyc counts cycles from the start edge and gos counts issues.
    task automatic applyStimulus(input vec_t v, output int cyc, output int gos);
        int g0;
        hit_en2     = v.hit_en;
        hit_nonce2  = v.hit_n;
        nonce_first = v.first;
        nonce_last  = v.last;
        g0          = go_cnt2;
        start2      = 1'b1;
        stepCycle();
        start2      = 1'b0;
        checkOutput({v.name, "_flags_cleared"}, {62'd0, found2, exh2}, 64'd0);
        checkOutput({v.name, "_count_cleared"}, 64'(cnt2), 64'd0);
        checkOutput({v.name, "_busy_after_start"}, 64'(busy2), 64'd1);
        waitIdle(2, v.name, cyc);
        gos = go_cnt2 - g0;
    endtask

    initial begin
        int   cyc;
        int   gos;
        int   g0;
        vec_t rv;

        vecs[0] = '{"hit_drain", 32'h10,       32'h1F,       1'b1, 32'h12,       1'b1, 1'b0, 32'h12,       4,  4,  12};
        vecs[1] = '{"exhaust16", 32'h100,      32'h10F,      1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        16, 16, 42};
        vecs[2] = '{"top_edge",  32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        2,  2,  7};
        vecs[3] = '{"top_hit",   32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 2,  2,  7};
        vecs[4] = '{"empty",     32'h5,        32'h4,        1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        0,  0,  1};

        // Reset values.
        rst = 1'b1;
        stepCycle();
        stepCycle();
        rst = 1'b0;
        checkOutput("rst_busy", 64'(busy2), 64'd0);
        checkOutput("rst_flags", {62'd0, found2, exh2}, 64'd0);
        checkOutput("rst_found_nonce", 64'(fn2), 64'd0);
        checkOutput("rst_hash_count", 64'(cnt2), 64'd0);
        checkOutput("rst_lane_go", {60'd0, go4}, 64'd0);
        checkOutput("rst_lane_nonce", nonce2, 64'd0);

        // Single lane, range 0..9, only nonce 5 hits.
        $display("[TB] single lane search");
        nonce_first = 32'd0;
        nonce_last  = 32'd9;
        start1 = 1'b1;
        stepCycle();
        start1 = 1'b0;
        waitIdle(1, "one_lane", cyc);
        checkOutput("one_lane_found", 64'(found1), 64'd1);
        checkOutput("one_lane_exhausted", 64'(exh1), 64'd0);
        checkOutput("one_lane_found_nonce", 64'(fn1), 64'd5);
        checkOutput("one_lane_raw_nonce5", 64'(raw5), 64'h05000000);
        checkOutput("one_lane_count", 64'(cnt1), 64'(expCnt(6)));
        checkOutput("one_lane_issues", 64'(go_cnt1), 64'd6);
        checkOutput("one_lane_done_cycle", 64'(cyc), 64'd37);

        // Table-driven searches on the two-lane instance.
        $display("[TB] two lane vector table");
        for (int k = 0; k < 5; k++) begin
            applyStimulus(vecs[k], cyc, gos);
            checkOutput({vecs[k].name, "_found"}, 64'(found2), 64'(vecs[k].exp_found));
            checkOutput({vecs[k].name, "_exhausted"}, 64'(exh2), 64'(vecs[k].exp_exh));
            checkOutput({vecs[k].name, "_found_nonce"}, 64'(fn2), 64'(vecs[k].exp_fn));
            checkOutput({vecs[k].name, "_issues"}, 64'(gos), 64'(vecs[k].exp_gos));
            checkOutput({vecs[k].name, "_count"}, 64'(cnt2), 64'(expCnt(vecs[k].exp_cnt)));
            checkOutput({vecs[k].name, "_done_cycle"}, 64'(cyc), 64'(vecs[k].exp_cyc));
        end

        // Abort with both lanes busy, then a start pulse while draining.
        $display("[TB] abort and restart");
        hit_en2     = 1'b0;
        nonce_first = 32'd0;
        nonce_last  = 32'd100;
        g0          = go_cnt2;
        start2 = 1'b1;
        stepCycle();
        start2 = 1'b0;
        stepCycle();
        stepCycle();
        stepCycle();
        abort = 1'b1;
        stepCycle();
        abort = 1'b0;
        checkOutput("abort_busy_in_drain", 64'(busy2), 64'd1);
        nonce_first = 32'h50;
        nonce_last  = 32'h60;
        start2 = 1'b1;
        stepCycle();
        start2 = 1'b0;
        waitIdle(2, "abort", cyc);
        checkOutput("abort_flags", {62'd0, found2, exh2}, 64'd0);
        checkOutput("abort_issues", 64'(go_cnt2 - g0), 64'd2);
        checkOutput("abort_count", 64'(cnt2), 64'(expCnt(2)));
        checkOutput("abort_done_cycle", 64'(cyc), 64'd2);
        rv = '{"restart", 32'h30, 32'h31, 1'b1, 32'h31, 1'b1, 1'b0, 32'h31, 2, 2, 7};
        applyStimulus(rv, cyc, gos);
        checkOutput("restart_found", 64'(found2), 64'd1);
        checkOutput("restart_found_nonce", 64'(fn2), 64'h31);
        checkOutput("restart_issues", 64'(gos), 64'd2);

        // Four lanes: every result arrives in one cycle; lanes 1 and 3 hit.
        $display("[TB] four lane tie and drain");
        nonce_first = 32'd0;
        nonce_last  = 32'd100;
        start4 = 1'b1;
        stepCycle();
        start4 = 1'b0;
        repeat (6) stepCycle();
        checkOutput("tie_issues", 64'(go_cnt4), 64'd4);
        done4 = 4'b1111;
        hash4 = {256'h0, MISS, TGT, MISS};
        stepCycle();
        done4 = 4'b0000;
        checkOutput("tie_found", 64'(found4), 64'd1);
        checkOutput("tie_found_nonce", 64'(fn4), 64'd1);
        stepCycle();
        checkOutput("tie_busy_done", 64'(busy4), 64'd0);
        checkOutput("tie_count", 64'(cnt4), 64'(expCnt(4)));

        // Second run: lane 2 alone hits while lanes 0, 1 and 3 are still busy.
        nonce_first = 32'h20;
        nonce_last  = 32'h40;
        start4 = 1'b1;
        stepCycle();
        start4 = 1'b0;
        checkOutput("drain_found_cleared", 64'(found4), 64'd0);
        repeat (6) stepCycle();
        g0 = go_cnt4;
        done4 = 4'b0100;
        hash4 = {MISS, 256'h0, MISS, MISS};
        stepCycle();
        done4 = 4'b0000;
        checkOutput("drain_found", 64'(found4), 64'd1);
        checkOutput("drain_found_nonce", 64'(fn4), 64'h22);
        repeat (3) stepCycle();
        checkOutput("drain_busy_waiting", 64'(busy4), 64'd1);
        done4 = 4'b1011;
        hash4 = '0;
        stepCycle();
        done4 = 4'b0000;
        checkOutput("drain_busy_last_edge", 64'(busy4), 64'd1);
        stepCycle();
        checkOutput("drain_busy_done", 64'(busy4), 64'd0);
        checkOutput("drain_nonce_held", 64'(fn4), 64'h22);
        checkOutput("drain_no_issue_after_hit", 64'(go_cnt4 - g0), 64'd0);
        checkOutput("drain_count", 64'(cnt4), 64'(expCnt(4)));

        // Reset in the middle of a search, followed by stale lane results.
        $display("[TB] reset mid search");
        hit_en2     = 1'b0;
        nonce_first = 32'h40;
        nonce_last  = 32'h100;
        start2 = 1'b1;
        stepCycle();
        start2 = 1'b0;
        repeat (3) stepCycle();
        checkOutput("midrst_running", 64'(busy2), 64'd1);
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        checkOutput("midrst_busy", 64'(busy2), 64'd0);
        checkOutput("midrst_flags", {62'd0, found2, exh2}, 64'd0);
        checkOutput("midrst_found_nonce", 64'(fn2), 64'd0);
        checkOutput("midrst_lane_nonce", nonce2, 64'd0);
        checkOutput("midrst_lane_go", {62'd0, go2}, 64'd0);
        g0 = go_cnt2;
        repeat (6) stepCycle();
        checkOutput("stale_count", 64'(cnt2), 64'd0);
        checkOutput("stale_busy", 64'(busy2), 64'd0);
        checkOutput("stale_no_issue", 64'(go_cnt2 - g0), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
